// File: rtl/square_iterative.sv
// Multi-cycle shift-add squarer: square = root*root + addend, one root bit per cycle.
// Rebuilds a radicand from a {root, remainder} pair, or squares a value when addend is zero.
module square_iterative #(
    parameter  int ROOT_BITS   = 8,
    parameter  int ADDEND_BITS = ROOT_BITS + 1,
    localparam int SQ_BITS     = 2 * ROOT_BITS + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [ROOT_BITS-1:0]   root,
    input  logic [ADDEND_BITS-1:0] addend,
    output logic                   busy,
    output logic                   data_valid,
    output logic [SQ_BITS-1:0]     square
);

    localparam int CNT_W = $clog2(ROOT_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROOT_BITS - 1);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t               state, state_next;
    logic [ROOT_BITS-1:0] mcand;
    logic [ROOT_BITS-1:0] mplier;
    logic [SQ_BITS-1:0]   acc;
    logic [CNT_W-1:0]     cnt;

    logic                 load;
    logic                 finish;
    logic [SQ_BITS-1:0]   partial;
    logic [SQ_BITS-1:0]   acc_sum;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == LAST_CNT) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == CALC);
        load   = (state == IDLE) && start;
        finish = (state == CALC) && (cnt == LAST_CNT);
    end

    // The last iteration's sum goes straight to square, so the result lands on the final CALC edge.
    always_comb begin
        partial = SQ_BITS'(mcand) << cnt;
        acc_sum = acc + (mplier[0] ? partial : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            square     <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= finish;
            if (load) begin
                mcand  <= root;
                mplier <= root;
                acc    <= SQ_BITS'(addend);
                cnt    <= '0;
            end else if (state == CALC) begin
                acc    <= acc_sum;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
            if (finish) begin
                square <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_square_iterative.sv
// Scoreboarded bench for square_iterative (ROOT_BITS=8): stimulus pushes expected
// results, a negedge monitor pops and compares on every data_valid pulse.
module tb_square_iterative;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  root;
    logic [8:0]  addend;
    logic        busy;
    logic        data_valid;
    logic [16:0] square;

    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [16:0] exp_q[$];

    square_iterative #(.ROOT_BITS(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .root       (root),
        .addend     (addend),
        .busy       (busy),
        .data_valid (data_valid),
        .square     (square)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every data_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && data_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                check("square", square, exp_q.pop_front());
            end
        end
    end

    task automatic wait_valid(output int cyc);
        int n = 0;
        while (!data_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("valid_timeout", 0, 1);
        cyc = cycle;
    endtask

    // One operation: checks busy length, single-cycle data_valid.
    task automatic run_op(input logic [7:0] r, input logic [8:0] a);
        int n = 0;
        @(negedge clk);
        root   = r;
        addend = a;
        start  = 1'b1;
        exp_q.push_back(17'(int'(r) * int'(r) + int'(a)));
        @(negedge clk);
        start = 1'b0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, 8);
        check("valid_pulse", data_valid, 1);
        @(negedge clk);
        check("valid_clear", data_valid, 0);
    endtask

    initial begin
        int t1, t2, t3, pulses;
        logic [7:0] r;
        logic [8:0] a;

        reset_n = 1'b0;
        start   = 1'b0;
        root    = '0;
        addend  = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", data_valid, 0);
        check("rst_square", square, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_op(8'd0,   9'd0);
        run_op(8'd255, 9'd0);
        run_op(8'd255, 9'd510);
        run_op(8'd255, 9'd511);
        check("bit16_set", square[16], 1);

        // Start pulsed mid-computation must be ignored.
        @(negedge clk);
        root = 8'd12; addend = 9'd3; start = 1'b1;
        exp_q.push_back(17'd147);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        root = 8'd200; addend = 9'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(t1);
        repeat (4) @(negedge clk);
        check("hold_square", square, 147);
        check("ignored_busy", busy, 0);

        // Start held high: back-to-back results nine cycles apart.
        @(negedge clk);
        root = 8'd1; addend = 9'd0; start = 1'b1;
        exp_q.push_back(17'd1);
        exp_q.push_back(17'd4);
        exp_q.push_back(17'd9);
        @(negedge clk);
        root = 8'd2;
        wait_valid(t1);
        @(negedge clk);
        root = 8'd3;
        wait_valid(t2);
        @(negedge clk);
        start = 1'b0;
        wait_valid(t3);
        check("stream_gap1", t2 - t1, 9);
        check("stream_gap2", t3 - t2, 9);
        @(negedge clk);

        // Reset in flight discards the result.
        @(negedge clk);
        root = 8'd100; addend = 9'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_square", square, 0);
        check("midrst_valid", data_valid, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (data_valid) pulses++;
        end
        check("midrst_no_valid", pulses, 0);
        run_op(8'd7, 9'd0);

        // Sweep of valid sqrt pairs: result always fits in 16 bits.
        for (int i = 0; i < 8; i++) begin
            r = 8'($urandom_range(255, 0));
            a = 9'($urandom_range(2 * int'(r), 0));
            run_op(r, a);
            check("sweep_msb", square[16], 0);
        end

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
